// File: rtl/hydra_pkg.sv
// Shared constants and types for the packet-SRAM allocator.
//   NUM_PORT   : ingress ports served by the allocator
//   NUM_SRAM   : shared packet SRAMs (power of two, scanned round-robin)
//   PAGE_W     : page count / pointer width used by sram_state
//   REQ_PAGE_W : width of a packet's page request from the port parser
package hydra_pkg;

  localparam int NUM_PORT   = 16;
  localparam int NUM_SRAM   = 32;
  localparam int PAGE_W     = 11;
  localparam int PORT_W     = 4;
  localparam int SRAM_W     = 5;
  localparam int REQ_PAGE_W = 7;
  localparam int STEP_W     = 6;

  typedef logic [PORT_W-1:0] port_idx_t;
  typedef logic [SRAM_W-1:0] sram_idx_t;
  typedef logic [PAGE_W-1:0] page_cnt_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } alloc_state_t;

endpackage

// File: rtl/alloc_port_fsm.sv
// Per-port allocation engine. Scans all SRAMs once per request, tracks the
// best candidate (most pages already held for the packet's destination) and
// emits lock / unlock requests to the shared lock table in the top level.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   cnt_i                  global rotating scan counter
//   req_vld_i/dest/pages   allocation request (sampled in IDLE)
//   release_i              drop the held SRAM (honoured in IDLE)
//   locked_i, owner_i      current lock table
//   free_space_i           free pages per SRAM
//   page_amount_i          pages held per SRAM for its request_port value
//   query_*_o              request_port write for this cycle's scanned SRAM
//   lock_*_o, unlock_*_o   lock table update requests
//   grant_vld_o/fail_o     one-cycle result pulses
//   grant_sram_o, held_o   currently held SRAM
module alloc_port_fsm
  import hydra_pkg::*;
#(
  parameter int unsigned PORT_ID = 0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  sram_idx_t                       cnt_i,
  input  logic                            req_vld_i,
  input  port_idx_t                       req_dest_i,
  input  logic [REQ_PAGE_W-1:0]           req_pages_i,
  input  logic                            release_i,
  input  logic [NUM_SRAM-1:0]             locked_i,
  input  logic [NUM_SRAM-1:0][PORT_W-1:0] owner_i,
  input  logic [NUM_SRAM-1:0][PAGE_W-1:0] free_space_i,
  input  logic [NUM_SRAM-1:0][PAGE_W-1:0] page_amount_i,
  output logic                            query_vld_o,
  output sram_idx_t                       query_sram_o,
  output port_idx_t                       query_dest_o,
  output logic                            lock_vld_o,
  output sram_idx_t                       lock_sram_o,
  output logic                            unlock_vld_o,
  output sram_idx_t                       unlock_sram_o,
  output logic                            grant_vld_o,
  output logic                            grant_fail_o,
  output sram_idx_t                       grant_sram_o,
  output logic                            held_o
);

  localparam sram_idx_t PORT_OFS = sram_idx_t'(PORT_ID);
  localparam port_idx_t PORT_IDX = port_idx_t'(PORT_ID);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_SRAM);

  alloc_state_t            state_q, state_d;
  logic [STEP_W-1:0]       step_q, step_d;
  port_idx_t               dest_q, dest_d;
  logic [REQ_PAGE_W-1:0]   pages_q, pages_d;
  logic                    best_vld_q, best_vld_d;
  sram_idx_t               best_q, best_d;
  page_cnt_t               best_amt_q, best_amt_d;
  sram_idx_t               eval_sram_q, eval_sram_d;
  logic                    held_q, held_d;
  sram_idx_t               grant_sram_q, grant_sram_d;
  logic                    grant_vld_q, grant_vld_d;
  logic                    grant_fail_q, grant_fail_d;

  logic cand_lock, cand_free, cand_better, cand;

  // Candidate test for the SRAM queried on the previous step; page_amount
  // reflects the request_port value written on that step.
  assign cand_lock   = !locked_i[eval_sram_q] || (owner_i[eval_sram_q] == PORT_IDX);
  assign cand_free   = free_space_i[eval_sram_q] >= {{(PAGE_W-REQ_PAGE_W){1'b0}}, pages_q};
  assign cand_better = !best_vld_q || (page_amount_i[eval_sram_q] > best_amt_q);
  assign cand        = cand_lock && cand_free && cand_better;

  always_comb begin
    state_d       = state_q;
    step_d        = step_q;
    dest_d        = dest_q;
    pages_d       = pages_q;
    best_vld_d    = best_vld_q;
    best_d        = best_q;
    best_amt_d    = best_amt_q;
    eval_sram_d   = eval_sram_q;
    held_d        = held_q;
    grant_sram_d  = grant_sram_q;
    grant_vld_d   = 1'b0;
    grant_fail_d  = 1'b0;
    // Rotating offset keeps every port on a different SRAM each cycle.
    query_sram_o  = cnt_i + PORT_OFS;
    query_dest_o  = dest_q;
    query_vld_o   = 1'b0;
    lock_vld_o    = 1'b0;
    lock_sram_o   = eval_sram_q;
    unlock_vld_o  = 1'b0;
    unlock_sram_o = grant_sram_q;

    unique case (state_q)
      IDLE: begin
        if (release_i && held_q) begin
          unlock_vld_o  = 1'b1;
          unlock_sram_o = grant_sram_q;
          held_d        = 1'b0;
        end
        if (req_vld_i) begin
          state_d    = SEARCH;
          dest_d     = req_dest_i;
          pages_d    = (req_pages_i == '0) ? REQ_PAGE_W'(1) : req_pages_i;
          best_vld_d = 1'b0;
          step_d     = '0;
        end
      end

      SEARCH: begin
        if (step_q < LAST_STEP) begin
          query_vld_o = 1'b1;
        end
        eval_sram_d = query_sram_o;
        // Step 0 has nothing to evaluate yet; the final step only drains.
        if ((step_q != '0) && cand) begin
          lock_vld_o  = 1'b1;
          lock_sram_o = eval_sram_q;
          best_vld_d  = 1'b1;
          best_d      = eval_sram_q;
          best_amt_d  = page_amount_i[eval_sram_q];
          // The held SRAM stays locked until the search outcome is known.
          if (best_vld_q && !(held_q && (best_q == grant_sram_q))) begin
            unlock_vld_o  = 1'b1;
            unlock_sram_o = best_q;
          end
        end
        step_d = step_q + STEP_W'(1);
        if (step_q == LAST_STEP) begin
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
        if (best_vld_q) begin
          grant_vld_d  = 1'b1;
          grant_sram_d = best_q;
          held_d       = 1'b1;
          if (held_q && (grant_sram_q != best_q)) begin
            unlock_vld_o  = 1'b1;
            unlock_sram_o = grant_sram_q;
          end
        end else begin
          grant_fail_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      step_q       <= '0;
      dest_q       <= '0;
      pages_q      <= '0;
      best_vld_q   <= 1'b0;
      best_q       <= '0;
      best_amt_q   <= '0;
      eval_sram_q  <= '0;
      held_q       <= 1'b0;
      grant_sram_q <= '0;
      grant_vld_q  <= 1'b0;
      grant_fail_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      dest_q       <= dest_d;
      pages_q      <= pages_d;
      best_vld_q   <= best_vld_d;
      best_q       <= best_d;
      best_amt_q   <= best_amt_d;
      eval_sram_q  <= eval_sram_d;
      held_q       <= held_d;
      grant_sram_q <= grant_sram_d;
      grant_vld_q  <= grant_vld_d;
      grant_fail_q <= grant_fail_d;
    end
  end

  assign grant_vld_o  = grant_vld_q;
  assign grant_fail_o = grant_fail_q;
  assign grant_sram_o = grant_sram_q;
  assign held_o       = held_q;

endmodule

// File: rtl/sram_allocator.sv
// Binds ingress ports to shared packet SRAMs. Owns the rotating scan
// counter, the SRAM lock/owner table and the registered request_port query
// towards the per-SRAM sram_state blocks; one alloc_port_fsm per port.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   req_vld/dest/pages  per-port allocation request
//   release_i         per-port release of the held SRAM ('release' is a
//                     reserved word in SystemVerilog)
//   free_space        free pages per SRAM
//   page_amount       pages held per SRAM for request_port[s]
//   request_port      registered dest-port query per SRAM
//   grant_vld/fail    one-cycle result pulses per port
//   grant_sram, held  SRAM held by each port
//   locked            SRAM lock bitmap
module sram_allocator
  import hydra_pkg::*;
(
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_PORT-1:0]                req_vld,
  input  logic [NUM_PORT-1:0][PORT_W-1:0]    req_dest,
  input  logic [NUM_PORT-1:0][REQ_PAGE_W-1:0] req_pages,
  input  logic [NUM_PORT-1:0]                release_i,
  input  logic [NUM_SRAM-1:0][PAGE_W-1:0]    free_space,
  input  logic [NUM_SRAM-1:0][PAGE_W-1:0]    page_amount,
  output logic [NUM_SRAM-1:0][PORT_W-1:0]    request_port,
  output logic [NUM_PORT-1:0]                grant_vld,
  output logic [NUM_PORT-1:0]                grant_fail,
  output logic [NUM_PORT-1:0][SRAM_W-1:0]    grant_sram,
  output logic [NUM_PORT-1:0]                held,
  output logic [NUM_SRAM-1:0]                locked
);

  sram_idx_t                       cnt_q;
  logic [NUM_SRAM-1:0]             locked_q, locked_d;
  logic [NUM_SRAM-1:0][PORT_W-1:0] owner_q, owner_d;
  logic [NUM_SRAM-1:0][PORT_W-1:0] request_port_q, request_port_d;

  logic [NUM_PORT-1:0] query_vld, lock_vld, unlock_vld;
  sram_idx_t           query_sram  [NUM_PORT];
  sram_idx_t           lock_sram   [NUM_PORT];
  sram_idx_t           unlock_sram [NUM_PORT];
  port_idx_t           query_dest  [NUM_PORT];

  generate
    for (genvar gi = 0; gi < NUM_PORT; gi++) begin : g_port
      alloc_port_fsm #(
        .PORT_ID(gi)
      ) u_fsm (
        .clk           (clk),
        .rst_n         (rst_n),
        .cnt_i         (cnt_q),
        .req_vld_i     (req_vld[gi]),
        .req_dest_i    (req_dest[gi]),
        .req_pages_i   (req_pages[gi]),
        .release_i     (release_i[gi]),
        .locked_i      (locked_q),
        .owner_i       (owner_q),
        .free_space_i  (free_space),
        .page_amount_i (page_amount),
        .query_vld_o   (query_vld[gi]),
        .query_sram_o  (query_sram[gi]),
        .query_dest_o  (query_dest[gi]),
        .lock_vld_o    (lock_vld[gi]),
        .lock_sram_o   (lock_sram[gi]),
        .unlock_vld_o  (unlock_vld[gi]),
        .unlock_sram_o (unlock_sram[gi]),
        .grant_vld_o   (grant_vld[gi]),
        .grant_fail_o  (grant_fail[gi]),
        .grant_sram_o  (grant_sram[gi]),
        .held_o        (held[gi])
      );
    end
  endgenerate

  // Lock and unlock never hit the same SRAM in one cycle (a port only locks
  // free or self-owned SRAMs and only unlocks its own), so order is moot.
  always_comb begin
    locked_d       = locked_q;
    owner_d        = owner_q;
    request_port_d = request_port_q;
    for (int p = 0; p < NUM_PORT; p++) begin
      if (unlock_vld[p]) begin
        locked_d[unlock_sram[p]] = 1'b0;
      end
    end
    for (int p = 0; p < NUM_PORT; p++) begin
      if (lock_vld[p]) begin
        locked_d[lock_sram[p]] = 1'b1;
        owner_d[lock_sram[p]]  = port_idx_t'(p);
      end
    end
    for (int p = 0; p < NUM_PORT; p++) begin
      if (query_vld[p]) begin
        request_port_d[query_sram[p]] = query_dest[p];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q          <= '0;
      locked_q       <= '0;
      owner_q        <= '0;
      request_port_q <= '0;
    end else begin
      cnt_q          <= cnt_q + sram_idx_t'(1);
      locked_q       <= locked_d;
      owner_q        <= owner_d;
      request_port_q <= request_port_d;
    end
  end

  assign locked       = locked_q;
  assign request_port = request_port_q;

endmodule

// File: tb/tb_sram_allocator.sv
module tb_sram_allocator;
  import hydra_pkg::*;

  logic                                clk;
  logic                                rst_n;
  logic [NUM_PORT-1:0]                 req_vld;
  logic [NUM_PORT-1:0][PORT_W-1:0]     req_dest;
  logic [NUM_PORT-1:0][REQ_PAGE_W-1:0] req_pages;
  logic [NUM_PORT-1:0]                 release_i;
  logic [NUM_SRAM-1:0][PAGE_W-1:0]     free_space;
  logic [NUM_SRAM-1:0][PAGE_W-1:0]     page_amount;
  logic [NUM_SRAM-1:0][PORT_W-1:0]     request_port;
  logic [NUM_PORT-1:0]                 grant_vld;
  logic [NUM_PORT-1:0]                 grant_fail;
  logic [NUM_PORT-1:0][SRAM_W-1:0]     grant_sram;
  logic [NUM_PORT-1:0]                 held;
  logic [NUM_SRAM-1:0]                 locked;

  sram_allocator dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_vld      (req_vld),
    .req_dest     (req_dest),
    .req_pages    (req_pages),
    .release_i    (release_i),
    .free_space   (free_space),
    .page_amount  (page_amount),
    .request_port (request_port),
    .grant_vld    (grant_vld),
    .grant_fail   (grant_fail),
    .grant_sram   (grant_sram),
    .held         (held),
    .locked       (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment: sram_state stand-in. page_amount follows the queried dest.
  logic [PAGE_W-1:0] fs_env  [NUM_SRAM];
  logic [PAGE_W-1:0] amt_env [NUM_PORT][NUM_SRAM];
  always_comb begin
    for (int s = 0; s < NUM_SRAM; s++) begin
      free_space[s]  = fs_env[s];
      page_amount[s] = amt_env[request_port[s]][s];
    end
  end

  // Reference scan counter: free-running from reset release.
  logic [4:0] tb_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_cnt <= '0;
    else        tb_cnt <= tb_cnt + 5'd1;
  end

  typedef struct {
    int port;
    bit fail;
    int sram;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    int port; int dest; int pages;
    int fs_all; int fs_sram; int fs_val;
    int a_s; int a_amt; int b_s; int b_amt;
    int start;
    bit exp_fail; int exp_sram;
  } row_t;
  row_t rows[8];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_env(input int fs_all, input int fs_sram, input int fs_val, input int dest,
                         input int a_s, input int a_amt, input int b_s, input int b_amt);
    for (int s = 0; s < NUM_SRAM; s++) begin
      fs_env[s] = PAGE_W'(fs_all);
      for (int d = 0; d < NUM_PORT; d++) amt_env[d][s] = '0;
    end
    if (fs_sram >= 0) fs_env[fs_sram] = PAGE_W'(fs_val);
    if (a_s >= 0) begin
      amt_env[dest][a_s] = PAGE_W'(a_amt);
      // Large count for another destination must not influence this search.
      amt_env[(dest + 1) % NUM_PORT][30] = 11'd500;
    end
    if (b_s >= 0) amt_env[dest][b_s] = PAGE_W'(b_amt);
  endtask

  // Request so that the first SRAM scanned by port p is 'start'.
  task automatic issue(input int p, input int dest, input int pages, input int start);
    int c0;
    int guard;
    c0 = (start - 1 - p) & 31;
    guard = 0;
    @(negedge clk);
    while (tb_cnt != 5'(c0) && guard < 64) begin
      @(negedge clk);
      guard++;
    end
    req_vld[p]   = 1'b1;
    req_dest[p]  = PORT_W'(dest);
    req_pages[p] = REQ_PAGE_W'(pages);
    @(posedge clk);
    @(negedge clk);
    req_vld = '0;
  endtask

  task automatic wait_grant(input int exp_lat, input int mon_bit, input string tag);
    int n;
    int drops;
    sb_t e;
    n = 0;
    drops = 0;
    while ((grant_vld | grant_fail) == '0 && n < 80) begin
      if (mon_bit >= 0 && !locked[mon_bit]) drops++;
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, n, exp_lat);
    if (mon_bit >= 0) check({tag, "_lock_kept"}, drops, 0);
    for (int p = 0; p < NUM_PORT; p++) begin
      if (grant_vld[p] || grant_fail[p]) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL %s_unexpected: port %0d pulsed, nothing expected", tag, p);
        end else begin
          e = sb_q.pop_front();
          check({tag, "_port"}, p, e.port);
          check({tag, "_fail"}, grant_fail[p], e.fail);
          check({tag, "_vld"}, grant_vld[p], !e.fail);
          if (!e.fail) check({tag, "_sram"}, grant_sram[p], e.sram);
          $display("txn %s: port %0d %s sram %0d latency %0d", tag, p,
                   grant_vld[p] ? "grant" : "nogrant", grant_sram[p], n);
        end
      end
    end
    @(negedge clk);
    check({tag, "_pulse_width"}, grant_vld | grant_fail, 0);
  endtask

  task automatic release_ports(input logic [NUM_PORT-1:0] mask, input string tag);
    release_i = mask;
    @(posedge clk);
    @(negedge clk);
    release_i = '0;
    check({tag, "_rel_locked"}, locked, 0);
    check({tag, "_rel_held"}, held & mask, 0);
    $display("txn %s: release mask 0x%0h", tag, mask);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    row_t r;
    int pulses;
    rows[0] = '{0, 3, 4, 2047, -1, 0, -1, 0, -1, 0, 5, 1'b0, 5};   // empty system
    rows[1] = '{5, 5, 4, 2047, -1, 0, 7, 10, 12, 20, 0, 1'b0, 12}; // affinity
    rows[2] = '{2, 1, 0, 1, -1, 0, 20, 3, -1, 0, 8, 1'b0, 20};     // 0 pages = 1
    rows[3] = '{9, 8, 127, 126, 4, 127, -1, 0, -1, 0, 0, 1'b0, 4}; // exact fit
    rows[4] = '{15, 15, 4, 3, -1, 0, -1, 0, -1, 0, 3, 1'b1, 0};    // no room
    rows[5] = '{3, 2, 4, 2047, -1, 0, 11, 50, 10, 50, 9, 1'b0, 10};// tie keeps first
    rows[6] = '{7, 0, 16, 2047, 6, 10, -1, 0, -1, 0, 6, 1'b0, 7};  // first too small
    rows[7] = '{12, 9, 2, 2047, -1, 0, 3, 40, 25, 20, 20, 1'b0, 3};// wrapped scan

    rst_n = 1'b0;
    req_vld = '0;
    req_dest = '0;
    req_pages = '0;
    release_i = '0;
    set_env(2047, -1, 0, 0, -1, 0, -1, 0);
    repeat (3) @(negedge clk);
    check("reset_locked", locked, 0);
    check("reset_held", held, 0);
    check("reset_grant", grant_vld | grant_fail, 0);
    check("reset_grant_sram_zero", grant_sram == '0, 1);
    check("reset_request_port_zero", request_port == '0, 1);
    rst_n = 1'b1;
    @(negedge clk);

    // Single-port table
    for (int i = 0; i < 8; i++) begin
      r = rows[i];
      set_env(r.fs_all, r.fs_sram, r.fs_val, r.dest, r.a_s, r.a_amt, r.b_s, r.b_amt);
      sb_q.push_back('{r.port, r.exp_fail, r.exp_sram});
      issue(r.port, r.dest, r.pages, r.start);
      wait_grant(34, -1, $sformatf("row%0d", i));
      check($sformatf("row%0d_held", i), held[r.port], !r.exp_fail);
      if (!r.exp_fail) begin
        check($sformatf("row%0d_locked", i), locked, 32'd1 << r.exp_sram);
        release_ports(16'd1 << r.port, $sformatf("row%0d", i));
      end else begin
        check($sformatf("row%0d_locked", i), locked, 0);
      end
    end

    // All ports at once: port i starts on SRAM i and keeps it.
    set_env(2047, -1, 0, 0, -1, 0, -1, 0);
    for (int p = 0; p < NUM_PORT; p++) sb_q.push_back('{p, 1'b0, p});
    @(negedge clk);
    for (int g = 0; g < 64 && tb_cnt != 5'd31; g++) @(negedge clk);
    for (int p = 0; p < NUM_PORT; p++) begin
      req_dest[p]  = 4'd2;
      req_pages[p] = 7'd4;
    end
    req_vld = '1;
    @(posedge clk);
    @(negedge clk);
    req_vld = '0;
    wait_grant(34, -1, "all16");
    check("all16_locked", locked, 32'h0000_FFFF);
    check("all16_held", held, 16'hFFFF);
    release_ports('1, "all16");

    // Held SRAM 9: re-grant, failed search, then move to a better SRAM.
    set_env(2047, -1, 0, 6, 9, 30, -1, 0);
    sb_q.push_back('{4, 1'b0, 9});
    issue(4, 6, 4, 0);
    wait_grant(34, -1, "hold_first");
    check("hold_first_locked", locked, 32'd1 << 9);
    sb_q.push_back('{4, 1'b0, 9});
    issue(4, 6, 4, 0);
    wait_grant(34, 9, "hold_regrant");
    check("hold_regrant_locked", locked, 32'd1 << 9);
    set_env(3, -1, 0, 6, 9, 30, -1, 0);
    sb_q.push_back('{4, 1'b1, 0});
    issue(4, 6, 4, 0);
    wait_grant(34, 9, "hold_fail");
    check("hold_fail_held", held, 16'd1 << 4);
    check("hold_fail_sram", grant_sram[4], 9);
    check("hold_fail_locked", locked, 32'd1 << 9);
    set_env(2047, -1, 0, 6, 9, 30, 20, 40);
    sb_q.push_back('{4, 1'b0, 20});
    issue(4, 6, 4, 0);
    wait_grant(34, 9, "hold_move");
    check("hold_move_locked", locked, 32'd1 << 20);
    release_ports(16'd1 << 4, "hold_move");

    // Reset in the middle of a search.
    set_env(2047, -1, 0, 0, -1, 0, -1, 0);
    issue(1, 3, 4, 0);
    repeat (15) @(negedge clk);
    check("rst_mid_locked_before", locked != '0, 1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_locked", locked, 0);
    check("rst_mid_held", held, 0);
    check("rst_mid_request_port_zero", request_port == '0, 1);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if ((grant_vld | grant_fail) != '0) pulses++;
    end
    check("rst_mid_no_pulse", pulses, 0);
    sb_q.push_back('{1, 1'b0, 0});
    issue(1, 3, 4, 0);
    wait_grant(34, -1, "after_rst");
    check("after_rst_locked", locked, 32'd1);
    release_ports(16'd1 << 1, "after_rst");

    check("scoreboard_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
